// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the Booth multiplier datapath and its BCD output stage.
//   PROD_W     : default product width, shared with the multiplier output
//   BCD_DIGITS : default number of BCD digits (10^BCD_DIGITS > 2^(PROD_W-1))
//   state_e    : converter FSM states
//   add3_adj   : one double-dabble digit correction (d >= 5 ? d + 3 : d)
package booth_pkg;

    localparam int PROD_W     = 9;
    localparam int BCD_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // A digit of 5..9 becomes 8..12, so the following left shift carries
    // out of the nibble exactly when the doubled digit would be >= 10.
    function automatic logic [3:0] add3_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3
// Combinational double-dabble correction for a single BCD digit.
//   din  : current digit
//   dout : din >= 5 ? din + 3 : din
module bcd_add3
    import booth_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = add3_adj(din);

endmodule

// File: rtl/booth_product_bcd.sv
// booth_product_bcd
// Converts one signed two's-complement product into sign + BCD magnitude
// using a shift-and-add-3 loop, one magnitude bit per clock.
//   clk, n_rst : clock, asynchronous active-low reset
//   in_valid   : product valid          in_ready  : accepting (IDLE only)
//   product    : signed product input
//   out_valid  : result held (DONE)     out_ready : consumer takes result
//   sign, bcd  : registered result, MS digit in the top nibble
//   busy       : conversion in progress
//   dbg_state  : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends combinationally on valid; a producer keeps
// its data stable while valid is high and not yet accepted. Here in_ready and
// out_valid are pure state decodes, so no input reaches an output directly.
module booth_product_bcd
    import booth_pkg::*;
#(
    parameter int IN_W   = PROD_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sign,
    output logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output state_e              dbg_state
);

    localparam int CNT_W = $clog2(IN_W);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    mag_q,   mag_d;
    logic [BCD_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               neg_q,   neg_d;
    logic               sign_q,  sign_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;

    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+IN_W-1:0]  shifted;
    logic [IN_W-1:0]        prod_abs;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // Magnitude fits in IN_W unsigned bits: the most negative input maps to
    // 2^(IN_W-1), whose bit pattern equals the input itself.
    assign prod_abs = product[IN_W-1] ? (~product + IN_W'(1)) : product;
    assign shifted  = {acc_adj, mag_q} << 1;

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    neg_d   = product[IN_W-1];
                    mag_d   = prod_abs;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = shifted[BCD_W+IN_W-1 -: BCD_W];
                mag_d = shifted[IN_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Published result changes only here, on entry to DONE.
                    bcd_d   = shifted[BCD_W+IN_W-1 -: BCD_W];
                    sign_d  = neg_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CONV);
    assign out_valid = (state_q == DONE);
    assign sign      = sign_q;
    assign bcd       = bcd_q;
    assign dbg_state = state_q;

endmodule
